// File: rtl/pmod_ad1_axis_packer.sv
// pmod_ad1_axis_packer
//   Packs pairs of 16-bit PMOD AD1 samples into 32-bit AXI4-Stream words for
//   a 32-bit DMA and buffers them in a small FIFO. The upstream capture stage
//   ignores TREADY, so samples offered while the FIFO is full are counted as
//   drops.
//
// Ports
//   CLK_i, RST_i           clock, asynchronous active-high reset
//   S_AXIS_T*              16-bit sample stream in ([11:0] data)
//   M_AXIS_T*              32-bit packed stream out, {second, first}
//                          TKEEP 4'hF full word, 4'h3 lone low sample
//   FIFO_LEVEL_o           words held (including the one presented)
//   DROP_COUNT_o           saturating count of samples offered while full
//   DROP_CLR_i             synchronous clear of DROP_COUNT_o (wins over +1)
//
// Configuration
//   PMOD_AD1_PACK_SEQ_EN   when defined, sample bits [15:12] carry a 4-bit
//                          per-frame sequence count for host gap detection.
module pmod_ad1_axis_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_i,
  input  logic                          RST_i,
  input  logic [15:0]                   S_AXIS_TDATA_i,
  input  logic                          S_AXIS_TVALID_i,
  input  logic                          S_AXIS_TLAST_i,
  output logic                          S_AXIS_TREADY_o,
  output logic [31:0]                   M_AXIS_TDATA_o,
  output logic [3:0]                    M_AXIS_TKEEP_o,
  output logic                          M_AXIS_TLAST_o,
  output logic                          M_AXIS_TVALID_o,
  input  logic                          M_AXIS_TREADY_i,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_o,
  output logic [15:0]                   DROP_COUNT_o,
  input  logic                          DROP_CLR_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {ST_EMPTY, ST_HALF} state_t;

  // Stored word: {last, full, data[31:0]}
  state_t          r_state, w_state_nxt;
  logic [15:0]     r_low;
  logic            r_started;
  logic [LW-1:0]   r_level;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [33:0]     r_mem [FIFO_DEPTH];
  logic [33:0]     r_out;
  logic            r_tvalid;
  logic [15:0]     r_drop;
  logic            w_ready, w_accept, w_pop, w_wr_en;
  logic [33:0]     w_wr_word;
  logic [15:0]     w_samp;

  // Ready looks only at the level register; r_started keeps it low during
  // reset and for the first cycle after release.
  assign w_ready  = r_started & (r_level < LW'(FIFO_DEPTH));
  assign w_accept = S_AXIS_TVALID_i & w_ready;
  assign w_pop    = r_tvalid & M_AXIS_TREADY_i;
  assign w_rd_nxt = r_rd_ptr + AW'(1);

`ifdef PMOD_AD1_PACK_SEQ_EN
  logic [3:0] r_seq;
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i)         r_seq <= '0;
    else if (w_accept) r_seq <= S_AXIS_TLAST_i ? 4'd0 : r_seq + 4'd1;
  end
  assign w_samp = {r_seq, S_AXIS_TDATA_i[11:0]};
`else
  assign w_samp = S_AXIS_TDATA_i;
`endif

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) r_started <= 1'b0;
    else       r_started <= 1'b1;
  end

  // Pack FSM: state register plus held low half
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_state <= ST_EMPTY;
      r_low   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && r_state == ST_EMPTY) r_low <= w_samp;
    end
  end

  // The completing accept writes the FIFO at its own clock edge, so the
  // level reflects the new word in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_word   = '0;
    case (r_state)
      ST_EMPTY: if (w_accept) begin
        if (S_AXIS_TLAST_i) begin
          w_wr_en   = 1'b1;
          w_wr_word = {1'b1, 1'b0, 16'h0000, w_samp};
        end else begin
          w_state_nxt = ST_HALF;
        end
      end
      ST_HALF: if (w_accept) begin
        w_wr_en     = 1'b1;
        w_wr_word   = {S_AXIS_TLAST_i, 1'b1, w_samp, r_low};
        w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge CLK_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= w_rd_nxt;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered read port. The presented word stays in the FIFO (and in the
  // level) until popped. On a pop, the next word is prefetched only if it
  // was already written, so a word written at this edge appears one cycle
  // later.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_tvalid <= 1'b0;
      r_out    <= '0;
    end else if (w_pop) begin
      r_tvalid <= (r_level > LW'(1));
      if (r_level > LW'(1)) r_out <= r_mem[w_rd_nxt];
    end else if (!r_tvalid && r_level != '0) begin
      r_tvalid <= 1'b1;
      r_out    <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i)                                          r_drop <= '0;
    else if (DROP_CLR_i)                                r_drop <= '0;
    else if (S_AXIS_TVALID_i && !w_ready && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  end

  assign S_AXIS_TREADY_o = w_ready;
  assign M_AXIS_TDATA_o  = r_out[31:0];
  assign M_AXIS_TKEEP_o  = r_out[32] ? 4'hF : 4'h3;
  assign M_AXIS_TLAST_o  = r_out[33];
  assign M_AXIS_TVALID_o = r_tvalid;
  assign FIFO_LEVEL_o    = r_level;
  assign DROP_COUNT_o    = r_drop;
endmodule
